bus_read_arbiter: RTL and testbench

BUS_READ_ARBITER -- requirements
Module: bus_read_arbiter

---
 rtl/bus_read_arbiter_if.sv | 27 ++
 rtl/bus_read_arbiter.sv | 110 +++++++++++
 tb/tb_bus_read_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_read_arbiter_if.sv
// Read channel bundle (address request + read data return) between one
// requester and one responder. The arbiter sits on the slave side of each
// master's channel and on the master side of the shared slave channel.
interface bus_read_arbiter_if;
  logic       arvalid;
  logic [7:0] araddr;
  logic [3:0] arlen;
  logic [3:0] arid;
  logic       arready;
  logic       rvalid;
  logic       rlast;
  logic [7:0] rdata;
  logic       rresp;
  logic       rready;

  // Requester view: issues addresses, accepts read beats.
  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rlast, rdata, rresp
  );

  // Responder view: accepts addresses, returns read beats.
  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rlast, rdata, rresp
  );
endinterface

// File: rtl/bus_read_arbiter.sv
// Two-master read arbiter: round-robin grant in IDLE, forwards the owner's
// address in ADDR, routes read beats back to the owner in DATA and flags
// bursts whose beat count disagrees with the requested length.
module bus_read_arbiter (
  input  logic                clk,
  input  logic                rst,
  bus_read_arbiter_if.slave   m0,
  bus_read_arbiter_if.slave   m1,
  bus_read_arbiter_if.master  s,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                len_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic       last_grant;   // index of the master that owned the previous burst
  logic [4:0] exp_cnt;      // arlen + 1 of the current burst
  logic [4:0] beat_cnt;     // beats accepted so far in the current burst

  logic       sel;
  logic       in_addr;
  logic       in_data;
  logic       ar_hs;
  logic       beat;
  logic [4:0] beat_num;
  logic       pick_m1;

  assign sel      = grant[1];
  assign in_addr  = (state == ADDR);
  assign in_data  = (state == DATA);
  assign ar_hs    = in_addr && s.arvalid && s.arready;
  assign beat     = in_data && s.rvalid && s.rready;
  assign beat_num = beat_cnt + 5'd1;

  // Master 1 wins if it is the only requester, or on a tie when master 0 owned last.
  assign pick_m1  = m1.arvalid && (!m0.arvalid || (last_grant == 1'b0));

  assign busy     = (state != IDLE);

  // Address channel: forward the owner's request only while in ADDR.
  assign s.arvalid  = in_addr && (sel ? m1.arvalid : m0.arvalid);
  assign s.araddr   = sel ? m1.araddr : m0.araddr;
  assign s.arlen    = sel ? m1.arlen  : m0.arlen;
  assign s.arid     = sel ? m1.arid   : m0.arid;
  assign m0.arready = in_addr && !sel && s.arready;
  assign m1.arready = in_addr &&  sel && s.arready;

  // Data channel: data and response fan out to both, only valid/last are steered.
  assign s.rready   = in_data && (sel ? m1.rready : m0.rready);
  assign m0.rvalid  = in_data && !sel && s.rvalid;
  assign m1.rvalid  = in_data &&  sel && s.rvalid;
  assign m0.rlast   = in_data && !sel && s.rlast;
  assign m1.rlast   = in_data &&  sel && s.rlast;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;

  // Arbitration FSM, burst length tracking and length-error pulse.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      exp_cnt    <= 5'd0;
      beat_cnt   <= 5'd0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.arvalid || m1.arvalid) begin
            grant <= pick_m1 ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            exp_cnt  <= {1'b0, s.arlen} + 5'd1;
            beat_cnt <= 5'd0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_num;
            // Early last, or the expected final beat arriving without last.
            len_err  <= s.rlast ? (beat_num != exp_cnt) : (beat_num == exp_cnt);
            if (s.rlast) begin
              state      <= IDLE;
              grant      <= 2'b00;
              last_grant <= sel;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Bench for bus_read_arbiter: directed scenarios followed by randomized
// bursts, each checked against a transaction-level model of the arbiter.
module tb_bus_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       busy;
  logic       len_err;

  bus_read_arbiter_if m0_if ();
  bus_read_arbiter_if m1_if ();
  bus_read_arbiter_if s_if ();

  bus_read_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int model_last = 1;   // owner of the previous burst, as the model sees it

  typedef struct packed {
    logic       arready;
    logic       rvalid;
    logic       rlast;
    logic [7:0] rdata;
    logic       rresp;
  } mobs_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mobs_t mobs(input int n);
    mobs_t r;
    if (n == 1) begin
      r.arready = m1_if.arready; r.rvalid = m1_if.rvalid; r.rlast = m1_if.rlast;
      r.rdata   = m1_if.rdata;   r.rresp  = m1_if.rresp;
    end else begin
      r.arready = m0_if.arready; r.rvalid = m0_if.rvalid; r.rlast = m0_if.rlast;
      r.rdata   = m0_if.rdata;   r.rresp  = m0_if.rresp;
    end
    return r;
  endfunction

  task automatic set_master(input int n, input bit v, input logic [7:0] a,
                            input logic [3:0] l, input logic [3:0] id);
    if (n == 1) begin
      m1_if.arvalid = v; m1_if.araddr = a; m1_if.arlen = l; m1_if.arid = id;
    end else begin
      m0_if.arvalid = v; m0_if.araddr = a; m0_if.arlen = l; m0_if.arid = id;
    end
  endtask

  task automatic set_arvalid(input int n, input bit v);
    if (n == 1) m1_if.arvalid = v; else m0_if.arvalid = v;
  endtask

  task automatic set_rready(input int n, input bit v);
    if (n == 1) m1_if.rready = v; else m0_if.rready = v;
  endtask

  task automatic idle_inputs();
    set_master(0, 1'b0, 8'h00, 4'h0, 4'h0);
    set_master(1, 1'b0, 8'h00, 4'h0, 4'h0);
    m0_if.rready = 1'b1;
    m1_if.rready = 1'b1;
    s_if.arready = 1'b0;
    s_if.rvalid  = 1'b0;
    s_if.rlast   = 1'b0;
    s_if.rdata   = 8'h00;
    s_if.rresp   = 1'b0;
  endtask

  // Round-robin rule: a lone requester wins; on a tie the previous non-owner wins.
  function automatic int winner(input bit r0, input bit r1);
    if (r0 && r1) return (model_last == 0) ? 1 : 0;
    return r0 ? 0 : 1;
  endfunction

  // One full transaction from IDLE. The slave returns `beats` beats with last
  // on the final one; the owner stalls 3 cycles at beat `stall_at`; reset is
  // applied after beat `rst_after`; `drop_addr` withdraws arvalid once in ADDR.
  task automatic run_burst(input bit r0, input bit r1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [3:0] l0, input logic [3:0] l1,
                           input int beats, input int stall_at, input int rst_after,
                           input bit drop_addr, input logic [7:0] dbase,
                           output int pulses);
    int         w;
    int         o;
    int         len;
    bit         exp_err;
    logic [7:0] dat;
    logic       resp;
    pulses = 0;

    check("idle_grant", grant, 2'b00);
    check("idle_busy", busy, 1'b0);
    set_master(0, r0, a0, l0, 4'h3);
    set_master(1, r1, a1, l1, 4'hC);
    w   = winner(r0, r1);
    o   = 1 - w;
    len = (w == 1) ? int'(l1) : int'(l0);
    #1;
    check("idle_s_arvalid", s_if.arvalid, 1'b0);
    check("idle_arready", mobs(w).arready, 1'b0);
    step();

    check("grant", grant, (w == 1) ? 2'b10 : 2'b01);
    check("addr_busy", busy, 1'b1);
    check("s_arvalid", s_if.arvalid, 1'b1);
    check("s_araddr", s_if.araddr, (w == 1) ? a1 : a0);
    check("s_arlen", s_if.arlen, len);
    check("s_arid", s_if.arid, (w == 1) ? 4'hC : 4'h3);
    check("addr_s_rready", s_if.rready, 1'b0);
    check("addr_rvalid", mobs(w).rvalid, 1'b0);

    if (drop_addr) begin
      set_arvalid(w, 1'b0);
      #1;
      check("drop_s_arvalid", s_if.arvalid, 1'b0);
      step();
      check("drop_grant", grant, (w == 1) ? 2'b10 : 2'b01);
      check("drop_busy", busy, 1'b1);
      set_arvalid(w, 1'b1);
      #1;
      check("redo_s_arvalid", s_if.arvalid, 1'b1);
    end

    s_if.arready = 1'b1;
    #1;
    check("own_arready", mobs(w).arready, 1'b1);
    check("other_arready", mobs(o).arready, 1'b0);
    step();
    set_arvalid(w, 1'b0);
    s_if.arready = 1'b0;
    #1;
    check("data_s_arvalid", s_if.arvalid, 1'b0);

    for (int k = 1; k <= beats; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        s_if.rvalid = 1'b0;
        #1;
        check("gap_rvalid", mobs(w).rvalid, 1'b0);
        check("gap_s_rready", s_if.rready, 1'b1);
        step();
        check("gap_len_err", len_err, 1'b0);
      end
      dat  = dbase + 8'(k - 1);
      resp = 1'($urandom_range(0, 1));
      s_if.rvalid = 1'b1;
      s_if.rdata  = dat;
      s_if.rresp  = resp;
      s_if.rlast  = (k == beats);
      #1;
      if (k == stall_at) begin
        for (int c = 0; c < 3; c++) begin
          set_rready(w, 1'b0);
          #1;
          check("stall_s_rready", s_if.rready, 1'b0);
          check("stall_rvalid", mobs(w).rvalid, 1'b1);
          step();
          check("stall_len_err", len_err, 1'b0);
          check("stall_busy", busy, 1'b1);
        end
        set_rready(w, 1'b1);
        #1;
      end
      check("s_rready", s_if.rready, 1'b1);
      check("own_rvalid", mobs(w).rvalid, 1'b1);
      check("own_rlast", mobs(w).rlast, (k == beats));
      check("own_rdata", mobs(w).rdata, dat);
      check("own_rresp", mobs(w).rresp, resp);
      check("other_rvalid", mobs(o).rvalid, 1'b0);
      check("other_rlast", mobs(o).rlast, 1'b0);
      check("other_rdata", mobs(o).rdata, dat);
      step();
      s_if.rvalid = 1'b0;
      s_if.rlast  = 1'b0;
      // Error when "this is the last beat" and "this is beat len+1" disagree.
      exp_err = ((k == beats) != (k == len + 1));
      #1;
      check("len_err", len_err, exp_err);
      if (len_err === 1'b1) pulses++;

      if (k == rst_after) begin
        set_arvalid(0, 1'b0);
        set_arvalid(1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_if.rvalid = 1'b1;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_s_rready", s_if.rready, 1'b0);
        check("rst_rvalid", mobs(w).rvalid, 1'b0);
        check("rst_s_arvalid", s_if.arvalid, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        s_if.rvalid = 1'b0;
        model_last = 1;
        return;
      end
    end

    check("end_grant", grant, 2'b00);
    check("end_busy", busy, 1'b0);
    model_last = w;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p;
    int r;
    int len;
    int beats;
    int mode;

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    check("reset_grant", grant, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_len_err", len_err, 1'b0);
    rst = 1'b0;
    #1;
    check("reset_s_arvalid", s_if.arvalid, 1'b0);
    check("reset_s_rready", s_if.rready, 1'b0);
    model_last = 1;

    // Both request from reset: m0 first, then m1 after m0's last beat.
    run_burst(1, 1, 8'h10, 8'h20, 4'd0, 4'd0, 1, 0, 0, 0, 8'h50, p);
    check("tie_first_pulses", p, 0);
    run_burst(0, 1, 8'h10, 8'h20, 4'd0, 4'd0, 1, 0, 0, 0, 8'h60, p);
    check("tie_second_pulses", p, 0);

    // Four-beat burst of 0xA1..0xA4 to m0, no length error.
    run_burst(1, 0, 8'h30, 8'h00, 4'd3, 4'd0, 4, 0, 0, 0, 8'hA1, p);
    check("len3_pulses", p, 0);

    // Early last on beat 2 of a four-beat request.
    run_burst(1, 0, 8'h31, 8'h00, 4'd3, 4'd0, 2, 0, 0, 0, 8'hB0, p);
    check("short_pulses", p, 1);

    // Two-beat request answered with three beats.
    run_burst(0, 1, 8'h00, 8'h41, 4'd0, 4'd1, 3, 0, 0, 0, 8'hC0, p);
    check("long_pulses", p, 2);

    // Owner backpressure for 3 cycles mid-burst, plus arvalid drop in ADDR.
    run_burst(1, 0, 8'h32, 8'h00, 4'd3, 4'd0, 4, 2, 0, 1, 8'hD0, p);
    check("stall_pulses", p, 0);

    // Reset after beat 1; the next tie must go to m0 again.
    run_burst(1, 0, 8'h33, 8'h00, 4'd3, 4'd0, 4, 0, 1, 0, 8'hE0, p);
    run_burst(1, 1, 8'h34, 8'h44, 4'd0, 4'd0, 1, 0, 0, 0, 8'hF0, p);
    run_burst(1, 1, 8'h35, 8'h45, 4'd0, 4'd0, 1, 0, 0, 0, 8'hF8, p);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      r     = $urandom_range(1, 3);
      len   = $urandom_range(0, 4);
      mode  = $urandom_range(0, 3);
      beats = len + 1;
      if (mode == 0 && len > 0) beats = len;
      if (mode == 1) beats = len + 2;
      run_burst(r[0], r[1], 8'($urandom), 8'($urandom), 4'(len), 4'(len),
                beats, $urandom_range(0, beats), 0, ($urandom_range(0, 3) == 0),
                8'($urandom), p);
      check("rand_pulses", p, (beats == len + 1) ? 0 : ((beats < len + 1) ? 1 : 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
